// File: rtl/branch_history_predictor.sv
// ---------------------------------------------------------------------------
// branch_history_predictor
//
// Dynamic conditional-branch predictor built from a table of 2-bit saturating
// counters. The fetcher queries it with the PC of a decoded branch and gets a
// combinational taken/not-taken guess. The reorder buffer trains it at commit
// with resolved outcomes. The block also keeps committed-branch statistics.
//
// Configuration macro:
//   BHP_GSHARE_EN  - when defined, the table index is the PC index XORed with
//                    the global history register (gshare). When undefined,
//                    the table is plain PC-indexed (bimodal). The history
//                    register is kept in both builds.
//
// Parameters:
//   ADDR_WIDTH       instruction address width (32)
//   BHT_INDEX_WIDTH  log2 of the number of counter entries (8 -> 256)
//   GHR_WIDTH        global history width, must be <= BHT_INDEX_WIDTH
//
// Ports:
//   clk_in                        in   clock, rising edge
//   rst_in                        in   asynchronous active-high reset
//   rdy_in                        in   global enable; low freezes all state
//   query_pos_from_fetcher        in   PC of the branch being fetched
//   if_jump_predicted_to_fetcher  out  combinational prediction (1 = taken)
//   enable_from_rob               in   one-cycle pulse per committed branch
//   jump_result_from_rob          in   resolved direction (1 = taken)
//   inst_pos_from_rob             in   PC of the committed branch
//   update_count                  out  committed branches seen (wraps)
//   taken_count                   out  committed branches taken (wraps)
// ---------------------------------------------------------------------------
module branch_history_predictor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BHT_INDEX_WIDTH = 8,
  parameter int GHR_WIDTH       = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] query_pos_from_fetcher,
  output logic                  if_jump_predicted_to_fetcher,
  input  logic                  enable_from_rob,
  input  logic                  jump_result_from_rob,
  input  logic [ADDR_WIDTH-1:0] inst_pos_from_rob,
  output logic [31:0]           update_count,
  output logic [31:0]           taken_count
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_WIDTH;

  // Weakly not-taken: the state every counter starts from after reset.
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Next value of a 2-bit saturating counter; it clamps at both ends and
  // never wraps.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt,
                                            input logic       taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) begin
        res = 2'b11;
      end else begin
        res = cnt + 2'b01;
      end
    end else begin
      if (cnt == 2'b00) begin
        res = 2'b00;
      end else begin
        res = cnt - 2'b01;
      end
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]                 bht_r [BHT_ENTRIES];
  logic [GHR_WIDTH-1:0]       ghr_r;
  logic [31:0]                update_count_r;
  logic [31:0]                taken_count_r;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [BHT_INDEX_WIDTH-1:0] query_pc_idx_s;
  logic [BHT_INDEX_WIDTH-1:0] upd_pc_idx_s;
  logic [BHT_INDEX_WIDTH-1:0] query_idx_s;
  logic [BHT_INDEX_WIDTH-1:0] upd_idx_s;
  logic [1:0]                 bht_next_s;
  logic [GHR_WIDTH-1:0]       ghr_next_s;
  logic                       upd_fire_s;

  // Word-aligned instructions: the low two PC bits and everything above the
  // index field play no part in indexing.
  logic                       unused_pc_bits_s;
  assign unused_pc_bits_s = ^{query_pos_from_fetcher[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2],
                              query_pos_from_fetcher[1:0],
                              inst_pos_from_rob[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2],
                              inst_pos_from_rob[1:0]};

  assign query_pc_idx_s = query_pos_from_fetcher[BHT_INDEX_WIDTH+1:2];
  assign upd_pc_idx_s   = inst_pos_from_rob[BHT_INDEX_WIDTH+1:2];
  assign upd_fire_s     = rdy_in & enable_from_rob;

`ifdef BHP_GSHARE_EN
  logic [BHT_INDEX_WIDTH-1:0] ghr_ext_s;

  // Fold the history into both indices. The update side sees the history as
  // it was before this edge's shift, because ghr_r is still the old value.
  always_comb begin
    ghr_ext_s                  = {BHT_INDEX_WIDTH{1'b0}};
    ghr_ext_s[GHR_WIDTH-1:0]   = ghr_r;
    query_idx_s                = query_pc_idx_s ^ ghr_ext_s;
    upd_idx_s                  = upd_pc_idx_s ^ ghr_ext_s;
  end
`else
  // Plain bimodal indexing; history is tracked but not consulted.
  always_comb begin
    query_idx_s = query_pc_idx_s;
    upd_idx_s   = upd_pc_idx_s;
  end
`endif

  // Next counter value for the entry being trained and next history value.
  always_comb begin
    bht_next_s    = sat_update(bht_r[upd_idx_s], jump_result_from_rob);
    ghr_next_s    = ghr_r << 1'b1;
    ghr_next_s[0] = jump_result_from_rob;
  end

  // Prediction reads the registered table directly, so a same-cycle update
  // to the queried entry is not visible until after the edge (no bypass).
  assign if_jump_predicted_to_fetcher = bht_r[query_idx_s][1];

  // Counter table: all entries return to weakly not-taken on reset; one entry
  // is trained per accepted commit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= CNT_WEAK_NT;
      end
    end else if (upd_fire_s) begin
      bht_r[upd_idx_s] <= bht_next_s;
    end
  end

  // Global history of committed outcomes, newest outcome in bit 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ghr_r <= {GHR_WIDTH{1'b0}};
    end else if (upd_fire_s) begin
      ghr_r <= ghr_next_s;
    end
  end

  // Commit statistics; both wrap naturally modulo 2^32.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      update_count_r <= 32'd0;
      taken_count_r  <= 32'd0;
    end else if (upd_fire_s) begin
      update_count_r <= update_count_r + 32'd1;
      taken_count_r  <= taken_count_r + {31'd0, jump_result_from_rob};
    end
  end

  assign update_count = update_count_r;
  assign taken_count  = taken_count_r;

endmodule
